spi_amp_adc_ctrl: RTL
=====================

# spi_amp_adc_ctrl

Parametrised controller for the board's programmable preamplifier (8-bit SPI gain word) and dual-channel simultaneous-sampling ADC (34-clock frame, two 14-bit samples). It generates `SPI_SCK`/`SPI_MOSI`/`AMP_CS`/`AD_CONV` from a configurable divider and executes gain writes on request with echo readback. It runs single-shot or free-running conversions and hands captured samples to the acquisition path with a one-cycle valid strobe.

## Interface
- `CLK_DIV`, 4: `clk` cycles per SCK half-period (≥2).
- `CONV_PULSE`, 2: `clk` cycles `AD_CONV` is held high.
- `CONV_GAP`, 16: idle `clk` cycles between frames in continuous mode.
- `SAMPLE_W`, 14: sample width (fixed by the ADC frame; ≤14).

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset. One clock; reset is synchronous and active-high.
- `gain_a`, `gain_b` in 4: per-channel gain codes; word sent is `{gain_b, gain_a}`, MSB first.
- `gain_wr` in 1: request a gain write (pulse).
- `start` in 1: request one conversion (pulse).
- `continuous` in 1: free-running conversions while high.
- `busy` out 1: any SPI frame or conversion gap in progress.
- `gain_ack` out 1: one-cycle pulse when a gain frame completes.
- `gain_echo` out 8: previous gain word shifted back on `AMP_DOUT`.
- `sample_a`, `sample_b` out SAMPLE_W: last captured samples, raw two's complement.
- `sample_valid` out 1: one-cycle strobe; samples updated in the same cycle.
- `SPI_SCK`, `SPI_MOSI`, `AMP_CS`, `AD_CONV` out 1: device pins.
- `AMP_DOUT`, `AD_DOUT` in 1: device serial outputs.

## Operation
- States: IDLE, AMP_SETUP, AMP_BIT, AMP_HOLD, CONV, CONV_WAIT, ADC_BIT, GAP.
- SCK period = 2·CLK_DIV cycles: low half first, then high half. MOSI is updated at the start of the low half. Inputs are sampled in the last cycle of the low half, i.e. at the rising edge.
- Gain write: AMP_CS low; AMP_SETUP lasts CLK_DIV cycles; AMP_BIT runs 8 SCK periods, bit 7 first, and shifts `AMP_DOUT` into the echo register; AMP_HOLD lasts CLK_DIV cycles. AMP_CS then goes high, `gain_echo` updates, and `gain_ack` pulses.
- Gain code is latched when `gain_wr` is accepted. Later input changes do not affect the frame in flight.
- Conversion: CONV drives `AD_CONV`=1 for CONV_PULSE cycles, CONV_WAIT lasts CLK_DIV cycles, then ADC_BIT runs 34 SCK periods.
  - Rising edges 1–2: discarded.
  - 3–16: sample_a, MSB first.
  - 17–18: discarded.
  - 19–32: sample_b, MSB first.
  - 33–34: discarded.
- In continuous mode the next CONV starts after GAP (CONV_GAP cycles). Dropping `continuous` finishes the current frame and returns to IDLE.
- Priority in IDLE/GAP: pending gain write > conversion. `gain_wr` or `start` arriving while busy is held in a one-deep pending flag; repeats coalesce. A new `gain_wr` re-latches the code.
- `start` while `continuous`=1 is ignored (already running).
- AMP_CS stays high throughout conversions. SCK idles low. MOSI idles 0.

## Timing
- Reset values:
  - Pins: `AMP_CS`=1, `SPI_SCK`=0, `SPI_MOSI`=0, `AD_CONV`=0.
  - Status: `busy`=0, `gain_ack`=0, `sample_valid`=0.
  - Data: samples=0, `gain_echo`=0.
  - Pending flags cleared; state IDLE.
- `rst` mid-frame aborts immediately: pins return to idle values on the next edge and no partial sample or echo is published.
- Start latency: a request accepted in IDLE at cycle 0 changes the pins at cycle 1.
- Gain frame: AMP_CS low for (16+2)·CLK_DIV cycles; `gain_ack` in the cycle after AMP_CS rises.
- Conversion: `sample_valid` fires CONV_PULSE + CLK_DIV + 68·CLK_DIV cycles after the first AD_CONV cycle.
- `busy` is high from the first active cycle until the cycle of `gain_ack`/`sample_valid`, and stays high through GAP.

## Structure
- Shared package `scope_pkg`:
  - state enum;
  - frame constants: ADC_FRAME_BITS=34, AMP_BITS=8, bit-window indices 3/16/19/32.
- Sub-module `spi_bit_engine`: divider plus SCK generation, a bit counter, and `rise`/`fall` enables. It is reused by both frame types.
- Top FSM: shift registers and pending flags.

## Test plan
- Gain write, CLK_DIV=4, `gain_a`=1, `gain_b`=1: MOSI shows 0x11 MSB first on rising edges; AMP_CS low 72 cycles; AMP_DOUT model returns 0xA5 → `gain_echo`=0xA5 with `gain_ack`.
- Single conversion, ADC model sends A=0x1ABC, B=0x0543: `sample_a`=0x1ABC, `sample_b`=0x0543; `sample_valid` at cycle 278 after the first AD_CONV cycle; AD_CONV high exactly 2 cycles.
- Continuous mode, CONV_GAP=16: consecutive `sample_valid` strobes 294 cycles apart. Drop `continuous` mid-frame → that frame completes, then IDLE.
- `gain_wr` during a conversion, plus a second `gain_wr` with new codes: exactly one gain frame after `sample_valid`, carrying the latest codes.
- `gain_wr` and `start` in the same cycle: gain frame first, then conversion, with no gap glitch on AMP_CS.
- `rst` asserted mid-ADC_BIT: next cycle pins are idle and `busy`=0; no `sample_valid`; samples are 0.

Source files
------------

// File: rtl/scope_pkg.sv
// Shared types and frame constants for the preamp/ADC serial controller.
// Bit-window indices count SCK rising edges from 1.
package scope_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AMP_SETUP,
    ST_AMP_BIT,
    ST_AMP_HOLD,
    ST_CONV,
    ST_CONV_WAIT,
    ST_ADC_BIT,
    ST_GAP
  } state_e;

  localparam int ADC_FRAME_BITS = 34;
  localparam int AMP_BITS       = 8;
  localparam int ADC_RAW_W      = 14;
  localparam int ADC_A_FIRST    = 3;
  localparam int ADC_A_LAST     = 16;
  localparam int ADC_B_FIRST    = 19;
  localparam int ADC_B_LAST     = 32;
  localparam int BIT_CNT_W      = 6;

  function automatic logic in_window(input logic [BIT_CNT_W-1:0] edge_num,
                                     input int first, input int last);
    return (int'(edge_num) >= first) && (int'(edge_num) <= last);
  endfunction

endpackage

// File: rtl/spi_bit_engine.sv
// SCK generator and bit counter shared by gain and ADC frames.
// Each bit period is CLK_DIV low cycles followed by CLK_DIV high cycles.
module spi_bit_engine
  import scope_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [BIT_CNT_W-1:0] nbits,
  output logic                 sck,
  output logic                 rise,
  output logic                 period_end,
  output logic                 done,
  output logic [BIT_CNT_W-1:0] bit_idx
);

  localparam int PERIOD = 2 * CLK_DIV;
  localparam int CNT_W  = $clog2(PERIOD);

  logic                 active_q, active_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_CNT_W-1:0] bit_q, bit_d;
  logic                 sck_q, sck_d;

  // rise marks the last low cycle: data is captured on the same edge SCK goes high
  assign rise       = active_q && (cnt_q == CNT_W'(CLK_DIV - 1));
  assign period_end = active_q && (cnt_q == CNT_W'(PERIOD - 1));
  assign done       = period_end && (bit_q == nbits - BIT_CNT_W'(1));
  assign bit_idx    = bit_q;
  assign sck        = sck_q;

  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    if (start) begin
      active_d = 1'b1;
      cnt_d    = '0;
      bit_d    = '0;
    end else if (active_q) begin
      if (period_end) begin
        cnt_d = '0;
        if (done) active_d = 1'b0;
        else      bit_d    = bit_q + BIT_CNT_W'(1);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    sck_d = active_d && (cnt_d >= CNT_W'(CLK_DIV));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      bit_q    <= '0;
      sck_q    <= 1'b0;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      sck_q    <= sck_d;
    end
  end

endmodule

// File: rtl/spi_amp_adc_ctrl.sv
// Preamp gain writer and dual-channel ADC frame reader on one SPI bus.
// All pins are registered from the next-state so they move one cycle after acceptance.
module spi_amp_adc_ctrl
  import scope_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int CONV_PULSE = 2,
  parameter int CONV_GAP   = 16,
  parameter int SAMPLE_W   = 14
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          gain_a,
  input  logic [3:0]          gain_b,
  input  logic                gain_wr,
  input  logic                start,
  input  logic                continuous,
  output logic                busy,
  output logic                gain_ack,
  output logic [7:0]          gain_echo,
  output logic [SAMPLE_W-1:0] sample_a,
  output logic [SAMPLE_W-1:0] sample_b,
  output logic                sample_valid,
  output logic                SPI_SCK,
  output logic                SPI_MOSI,
  output logic                AMP_CS,
  output logic                AD_CONV,
  input  logic                AMP_DOUT,
  input  logic                AD_DOUT
);

  localparam int WAIT_W = 16;

  state_e                state_q, state_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic                  gain_pend_q, gain_pend_d;
  logic                  start_pend_q, start_pend_d;
  logic [7:0]            pend_word_q, pend_word_d;
  logic [7:0]            amp_sr_q, amp_sr_d;
  logic [7:0]            echo_sr_q, echo_sr_d;
  logic [ADC_RAW_W-1:0]  sh_a_q, sh_a_d, sh_b_q, sh_b_d;
  logic [SAMPLE_W-1:0]   sample_a_q, sample_a_d, sample_b_q, sample_b_d;
  logic [7:0]            gain_echo_q, gain_echo_d;
  logic                  gain_ack_q, gain_ack_d;
  logic                  sample_valid_q, sample_valid_d;
  logic                  mosi_q, mosi_d;
  logic                  cs_q, cs_d;
  logic                  conv_q, conv_d;
  logic                  busy_q, busy_d;

  logic                  eng_start, eng_rise, eng_period_end, eng_done;
  logic [BIT_CNT_W-1:0]  eng_bit, eng_nbits, edge_num;
  logic                  gain_req, conv_req, dispatch, go_amp, go_conv;

  assign eng_nbits = (state_q == ST_ADC_BIT) ? BIT_CNT_W'(ADC_FRAME_BITS)
                                             : BIT_CNT_W'(AMP_BITS);
  assign edge_num  = eng_bit + BIT_CNT_W'(1);

  spi_bit_engine #(.CLK_DIV(CLK_DIV)) u_engine (
    .clk        (clk),
    .rst        (rst),
    .start      (eng_start),
    .nbits      (eng_nbits),
    .sck        (SPI_SCK),
    .rise       (eng_rise),
    .period_end (eng_period_end),
    .done       (eng_done),
    .bit_idx    (eng_bit)
  );

  always_comb begin
    state_d        = state_q;
    wait_d         = (wait_q != '0) ? wait_q - WAIT_W'(1) : wait_q;
    pend_word_d    = gain_wr ? {gain_b, gain_a} : pend_word_q;
    amp_sr_d       = amp_sr_q;
    echo_sr_d      = echo_sr_q;
    sh_a_d         = sh_a_q;
    sh_b_d         = sh_b_q;
    sample_a_d     = sample_a_q;
    sample_b_d     = sample_b_q;
    gain_echo_d    = gain_echo_q;
    gain_ack_d     = 1'b0;
    sample_valid_d = 1'b0;
    mosi_d         = mosi_q;
    eng_start      = 1'b0;
    dispatch       = 1'b0;
    go_amp         = 1'b0;
    go_conv        = 1'b0;
    gain_req       = gain_wr | gain_pend_q;
    conv_req       = (start & ~continuous) | start_pend_q | continuous;

    case (state_q)
      ST_IDLE: dispatch = 1'b1;
      ST_AMP_SETUP: if (wait_q == '0) begin
        state_d   = ST_AMP_BIT;
        eng_start = 1'b1;
        mosi_d    = amp_sr_q[7];
        amp_sr_d  = {amp_sr_q[6:0], 1'b0};
      end
      ST_AMP_BIT: begin
        if (eng_rise) echo_sr_d = {echo_sr_q[6:0], AMP_DOUT};
        if (eng_done) begin
          state_d = ST_AMP_HOLD;
          wait_d  = WAIT_W'(CLK_DIV - 1);
          mosi_d  = 1'b0;
        end else if (eng_period_end) begin
          mosi_d   = amp_sr_q[7];
          amp_sr_d = {amp_sr_q[6:0], 1'b0};
        end
      end
      ST_AMP_HOLD: if (wait_q == '0) begin
        gain_ack_d  = 1'b1;
        gain_echo_d = echo_sr_q;
        dispatch    = 1'b1;
      end
      ST_CONV: if (wait_q == '0) begin
        state_d = ST_CONV_WAIT;
        wait_d  = WAIT_W'(CLK_DIV - 1);
      end
      ST_CONV_WAIT: if (wait_q == '0) begin
        state_d   = ST_ADC_BIT;
        eng_start = 1'b1;
      end
      ST_ADC_BIT: begin
        if (eng_rise && in_window(edge_num, ADC_A_FIRST, ADC_A_LAST))
          sh_a_d = {sh_a_q[ADC_RAW_W-2:0], AD_DOUT};
        if (eng_rise && in_window(edge_num, ADC_B_FIRST, ADC_B_LAST))
          sh_b_d = {sh_b_q[ADC_RAW_W-2:0], AD_DOUT};
        if (eng_done) begin
          sample_a_d     = sh_a_q[ADC_RAW_W-1 -: SAMPLE_W];
          sample_b_d     = sh_b_q[ADC_RAW_W-1 -: SAMPLE_W];
          sample_valid_d = 1'b1;
          if (continuous && !gain_req) begin
            state_d = ST_GAP;
            wait_d  = WAIT_W'(CONV_GAP - 1);
          end else begin
            dispatch = 1'b1;
          end
        end
      end
      ST_GAP: if (gain_req || !continuous || wait_q == '0) dispatch = 1'b1;
      default: state_d = ST_IDLE;
    endcase

    // A pending gain write always wins over a conversion request
    if (dispatch) begin
      if (gain_req)      go_amp  = 1'b1;
      else if (conv_req) go_conv = 1'b1;
      else               state_d = ST_IDLE;
    end
    if (go_amp) begin
      state_d   = ST_AMP_SETUP;
      wait_d    = WAIT_W'(CLK_DIV - 1);
      amp_sr_d  = pend_word_d;
      echo_sr_d = '0;
    end
    if (go_conv) begin
      state_d = ST_CONV;
      wait_d  = WAIT_W'(CONV_PULSE - 1);
    end

    gain_pend_d  = go_amp  ? 1'b0 : (gain_pend_q | gain_wr);
    start_pend_d = go_conv ? 1'b0 : (start_pend_q | (start & ~continuous));

    cs_d   = !(state_d inside {ST_AMP_SETUP, ST_AMP_BIT, ST_AMP_HOLD});
    conv_d = (state_d == ST_CONV);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      wait_q         <= '0;
      gain_pend_q    <= 1'b0;
      start_pend_q   <= 1'b0;
      pend_word_q    <= '0;
      amp_sr_q       <= '0;
      echo_sr_q      <= '0;
      sh_a_q         <= '0;
      sh_b_q         <= '0;
      sample_a_q     <= '0;
      sample_b_q     <= '0;
      gain_echo_q    <= '0;
      gain_ack_q     <= 1'b0;
      sample_valid_q <= 1'b0;
      mosi_q         <= 1'b0;
      cs_q           <= 1'b1;
      conv_q         <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      wait_q         <= wait_d;
      gain_pend_q    <= gain_pend_d;
      start_pend_q   <= start_pend_d;
      pend_word_q    <= pend_word_d;
      amp_sr_q       <= amp_sr_d;
      echo_sr_q      <= echo_sr_d;
      sh_a_q         <= sh_a_d;
      sh_b_q         <= sh_b_d;
      sample_a_q     <= sample_a_d;
      sample_b_q     <= sample_b_d;
      gain_echo_q    <= gain_echo_d;
      gain_ack_q     <= gain_ack_d;
      sample_valid_q <= sample_valid_d;
      mosi_q         <= mosi_d;
      cs_q           <= cs_d;
      conv_q         <= conv_d;
      busy_q         <= busy_d;
    end
  end

  assign busy         = busy_q;
  assign gain_ack     = gain_ack_q;
  assign gain_echo    = gain_echo_q;
  assign sample_a     = sample_a_q;
  assign sample_b     = sample_b_q;
  assign sample_valid = sample_valid_q;
  assign SPI_MOSI     = mosi_q;
  assign AMP_CS       = cs_q;
  assign AD_CONV      = conv_q;

endmodule
